// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder.
//   XLEN / ADDR_SIZE : data and byte-address widths (macros, defaulted here)
//   size_t           : access-size codes carried on req_swhb
//   state_t          : responder FSM state encoding
//   load_extract     : picks the addressed lane from a RAM word and extends it
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

package dmem_responder_pkg;

   typedef enum logic [1:0] {
      SZ_ILLEGAL = 2'b00,
      SZ_WORD    = 2'b01,
      SZ_HALF    = 2'b10,
      SZ_BYTE    = 2'b11
   } size_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_t;

   // Byte uses off[1:0], half uses off[1] only, word is passed through.
   function automatic logic [`XLEN-1:0] load_extract(input logic [31:0] word,
                                                     input logic [1:0]  off,
                                                     input size_t       sz,
                                                     input logic        uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [`XLEN-1:0] res;
      b = 8'(word >> {off, 3'b000});
      h = off[1] ? word[31:16] : word[15:0];
      case (sz)
         SZ_BYTE: res = uns ? {{(`XLEN-8){1'b0}}, b}  : {{(`XLEN-8){b[7]}}, b};
         SZ_HALF: res = uns ? {{(`XLEN-16){1'b0}}, h} : {{(`XLEN-16){h[15]}}, h};
         SZ_WORD: res = `XLEN'(word);
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous data RAM, 32-bit words, per-byte write enables,
// one-cycle registered read (read returns the pre-write contents).
//   clk   : clock
//   addr  : word index
//   be    : byte write enables, be[i] writes wdata[8i+7:8i]
//   wdata : write data
//   rdata : read data, valid the cycle after addr is presented
// Indices at or above DEPTH are ignored on write and read back as zero.
module dmem_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    be,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];
   logic        in_range;

   assign in_range = (32'(addr) < 32'(DEPTH));

   always_ff @(posedge clk) begin
      if (in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
         rdata <= mem[addr];
      end else begin
         rdata <= '0;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store request at a time, performs
// it against dmem_ram and holds the response until the initiator takes it.
//   clk, reset                     : clock, synchronous active-high reset
//   req_valid/req_ready            : request handshake
//   req_we, req_addr, req_wdata    : store flag, byte address, lane-positioned data
//   req_amp                        : store byte enables
//   req_swhb, req_unsigned         : access size and load extension mode
//   rsp_valid/rsp_ready            : response handshake
//   rsp_rdata, rsp_err             : extended load data, access fault
// Build option: define DMEM_MISALIGN_CHK_EN to fault misaligned halves/words;
// otherwise the offending low address bits are simply ignored.
//
// state     | meaning
// ST_IDLE   | req_ready high, waiting for a request
// ST_ACCESS | RAM write (stores) and lane extraction (loads)
// ST_RESP   | response held until rsp_ready
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [`ADDR_SIZE-1:0] req_addr,
   input  logic [`XLEN-1:0]      req_wdata,
   input  logic [3:0]            req_amp,
   input  logic [1:0]            req_swhb,
   input  logic                  req_unsigned,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [`XLEN-1:0]      rsp_rdata,
   output logic                  rsp_err
);

   state_t                state;
   logic                  l_we;
   logic [`ADDR_SIZE-1:0] l_addr;
   logic [`XLEN-1:0]      l_wdata;
   logic [3:0]            l_amp;
   size_t                 l_swhb;
   logic                  l_unsigned;

   logic                  out_of_range;
   logic                  misalign;
   logic                  access_err;
   logic [AW-1:0]         ram_addr;
   logic [3:0]            ram_be;
   logic [31:0]           ram_rdata;
   logic [`XLEN-1:0]      load_data;

   assign out_of_range = ({2'b00, l_addr[`ADDR_SIZE-1:2]} >= `ADDR_SIZE'(DEPTH_WORDS));

`ifdef DMEM_MISALIGN_CHK_EN
   assign misalign = ((l_swhb == SZ_HALF) && l_addr[0]) ||
                     ((l_swhb == SZ_WORD) && (l_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign access_err = out_of_range || (l_swhb == SZ_ILLEGAL) || misalign;

   // The read is launched from the live request address while idle so the
   // word is already on ram_rdata during ACCESS; the write uses the latched
   // fields at the end of ACCESS and is suppressed if reset lands there.
   assign ram_addr = (state == ST_ACCESS) ? l_addr[AW+1:2] : req_addr[AW+1:2];
   assign ram_be   = ((state == ST_ACCESS) && l_we && !access_err && !reset) ? l_amp : 4'b0000;

   assign load_data = (access_err || l_we) ? '0 :
                      load_extract(ram_rdata, l_addr[1:0], l_swhb, l_unsigned);

   dmem_ram #(
      .DEPTH (DEPTH_WORDS),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .addr  (ram_addr),
      .be    (ram_be),
      .wdata (32'(l_wdata)),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         req_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         l_we       <= 1'b0;
         l_addr     <= '0;
         l_wdata    <= '0;
         l_amp      <= '0;
         l_swhb     <= SZ_ILLEGAL;
         l_unsigned <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_ready && req_valid) begin
                  l_we       <= req_we;
                  l_addr     <= req_addr;
                  l_wdata    <= req_wdata;
                  l_amp      <= req_amp;
                  l_swhb     <= size_t'(req_swhb);
                  l_unsigned <= req_unsigned;
                  req_ready  <= 1'b0;
                  state      <= ST_ACCESS;
               end else begin
                  req_ready  <= 1'b1;
               end
            end
            ST_ACCESS: begin
               rsp_valid <= 1'b1;
               rsp_rdata <= load_data;
               rsp_err   <= access_err;
               state     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b0;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int DEPTH = 1000;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_amp;
   logic [1:0]  req_swhb;
   logic        req_unsigned;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checks   = 0;
   int failures = 0;

   logic [7:0] mem_m [0:4*DEPTH-1];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .AW(10)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_amp      (req_amp),
      .req_swhb     (req_swhb),
      .req_unsigned (req_unsigned),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: memory as a flat byte array, responses from the access rules.
   function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] amp, input logic [1:0] swhb, input logic uns,
                                 output logic [31:0] rd, output logic err);
      longint unsigned widx;
      int base, off, v;
      widx = longint'(addr) / 4;
      err  = (widx >= DEPTH) || (swhb == 2'b00);
`ifdef DMEM_MISALIGN_CHK_EN
      if (swhb == 2'b10 && (addr % 2) != 0) err = 1'b1;
      if (swhb == 2'b01 && (addr % 4) != 0) err = 1'b1;
`endif
      rd = 32'h0;
      if (err) return;
      base = int'(widx) * 4;
      if (we) begin
         for (int i = 0; i < 4; i++)
            if (amp[i]) mem_m[base+i] = 8'((wdata >> (8*i)) & 32'hFF);
      end else begin
         case (swhb)
            2'b01: rd = {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
            2'b10: begin
               off = ((addr % 4) >= 2) ? 2 : 0;
               v = int'(mem_m[base+off]) + 256 * int'(mem_m[base+off+1]);
               if (!uns && v >= 32768) v = v - 65536;
               rd = 32'(v);
            end
            default: begin
               off = int'(addr % 4);
               v = int'(mem_m[base+off]);
               if (!uns && v >= 128) v = v - 256;
               rd = 32'(v);
            end
         endcase
      end
   endfunction

   // Runs one transaction; reports what it observed, compares nothing.
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] amp, input logic [1:0] swhb, input logic uns,
                         input int hold,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output logic stable, output logic rr_after);
      int n;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      req_amp = amp; req_swhb = swhb; req_unsigned = uns;
      stable = 1'b1; rr_after = 1'b0; rdata = 'x; err = 1'bx;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) begin
         lat = -1; req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we = $urandom; req_addr = $urandom; req_wdata = $urandom;
      req_amp = 4'($urandom); req_swhb = 2'($urandom); req_unsigned = $urandom;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
      rdata = rsp_rdata; err = rsp_err;
      if (req_ready !== 1'b0) stable = 1'b0;
      repeat (hold) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_err !== err || req_ready !== 1'b0)
            stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      rr_after = (req_ready === 1'b1) && (rsp_valid === 1'b0);
   endtask

   task automatic test_reset;
      reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_we = 0; req_addr = 0;
      req_wdata = 0; req_amp = 0; req_swhb = 0; req_unsigned = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
      checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready_in_reset got=%b want=0", req_ready); end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready_after got=%b want=1", req_ready); end
   endtask

   task automatic test_fill;
      logic [31:0] rd, m_rd, w, a; logic er, m_er, st, rr; int lat;
      for (int i = 0; i < 74; i++) begin
         a = (i < 64) ? 32'(4*i) : 32'(4*(DEPTH-10+(i-64)));
         w = $urandom;
         model(1'b1, a, w, 4'hF, 2'b01, 1'b0, m_rd, m_er);
         do_req(1'b1, a, w, 4'hF, 2'b01, 1'b0, 0, rd, er, lat, st, rr);
         checks++; if (er !== m_er || rd !== m_rd) begin failures++; $display("FAIL fill_store addr=%h got err=%b rd=%h want err=%b rd=%h", a, er, rd, m_er, m_rd); end
      end
   endtask

   task automatic test_directed;
      logic [31:0] rd, m_rd; logic er, m_er, st, rr; int lat;
      model(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2'b01, 1'b0, m_rd, m_er);
      do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2'b01, 1'b0, 0, rd, er, lat, st, rr);
      checks++; if (lat !== 2) begin failures++; $display("FAIL store_latency got=%0d want=2", lat); end
      checks++; if (er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL store_rsp got err=%b rd=%h want err=0 rd=0", er, rd); end
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 2'b01, 1'b0, 0, rd, er, lat, st, rr);
      checks++; if (lat !== 2) begin failures++; $display("FAIL load_latency got=%0d want=2", lat); end
      checks++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin failures++; $display("FAIL load_word got err=%b rd=%h want err=0 rd=deadbeef", er, rd); end
      do_req(1'b0, 32'h13, 32'h0, 4'h0, 2'b11, 1'b0, 0, rd, er, lat, st, rr);
      checks++; if (rd !== 32'hFFFFFFDE) begin failures++; $display("FAIL load_byte_signed got=%h want=ffffffde", rd); end
      do_req(1'b0, 32'h13, 32'h0, 4'h0, 2'b11, 1'b1, 0, rd, er, lat, st, rr);
      checks++; if (rd !== 32'h000000DE) begin failures++; $display("FAIL load_byte_unsigned got=%h want=000000de", rd); end
      do_req(1'b0, 32'h12, 32'h0, 4'h0, 2'b10, 1'b0, 0, rd, er, lat, st, rr);
      checks++; if (rd !== 32'hFFFFDEAD) begin failures++; $display("FAIL load_half_signed got=%h want=ffffdead", rd); end
      model(1'b1, 32'h12, 32'h00AA0000, 4'b0100, 2'b10, 1'b0, m_rd, m_er);
      do_req(1'b1, 32'h12, 32'h00AA0000, 4'b0100, 2'b10, 1'b0, 0, rd, er, lat, st, rr);
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 2'b01, 1'b0, 0, rd, er, lat, st, rr);
      checks++; if (er !== 1'b0 || rd !== 32'hDEAABEEF) begin failures++; $display("FAIL partial_store got err=%b rd=%h want err=0 rd=deaabeef", er, rd); end
   endtask

   task automatic test_backpressure;
      logic [31:0] rd; logic er, st, rr; int lat;
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 2'b01, 1'b0, 5, rd, er, lat, st, rr);
      checks++; if (st !== 1'b1) begin failures++; $display("FAIL hold_stable got=%b want=1", st); end
      checks++; if (rd !== 32'hDEAABEEF) begin failures++; $display("FAIL hold_rdata got=%h want=deaabeef", rd); end
      checks++; if (rr !== 1'b1) begin failures++; $display("FAIL hold_ready_after got=%b want=1", rr); end
   endtask

   task automatic test_errors;
      logic [31:0] rd, m_rd; logic er, m_er, st, rr; int lat;
      do_req(1'b0, 32'h11, 32'h0, 4'h0, 2'b01, 1'b0, 0, rd, er, lat, st, rr);
`ifdef DMEM_MISALIGN_CHK_EN
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL misaligned_word got err=%b rd=%h want err=1 rd=0", er, rd); end
`else
      checks++; if (er !== 1'b0 || rd !== 32'hDEAABEEF) begin failures++; $display("FAIL misaligned_word got err=%b rd=%h want err=0 rd=deaabeef", er, rd); end
`endif
      do_req(1'b0, 32'(4*DEPTH), 32'h0, 4'h0, 2'b01, 1'b0, 0, rd, er, lat, st, rr);
      checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin failures++; $display("FAIL out_of_range got err=%b rd=%h lat=%0d want err=1 rd=0 lat=2", er, rd, lat); end
      do_req(1'b0, 32'h1000, 32'h0, 4'h0, 2'b11, 1'b1, 0, rd, er, lat, st, rr);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL out_of_range_pow2 got err=%b rd=%h want err=1 rd=0", er, rd); end
      model(1'b0, 32'(4*DEPTH-4), 32'h0, 4'h0, 2'b01, 1'b0, m_rd, m_er);
      do_req(1'b0, 32'(4*DEPTH-4), 32'h0, 4'h0, 2'b01, 1'b0, 0, rd, er, lat, st, rr);
      checks++; if (er !== 1'b0 || rd !== m_rd) begin failures++; $display("FAIL last_word got err=%b rd=%h want err=0 rd=%h", er, rd, m_rd); end
      do_req(1'b1, 32'h20, 32'h12345678, 4'hF, 2'b00, 1'b0, 0, rd, er, lat, st, rr);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL illegal_size got err=%b rd=%h want err=1 rd=0", er, rd); end
      model(1'b0, 32'h20, 32'h0, 4'h0, 2'b01, 1'b0, m_rd, m_er);
      do_req(1'b0, 32'h20, 32'h0, 4'h0, 2'b01, 1'b0, 0, rd, er, lat, st, rr);
      checks++; if (rd !== m_rd) begin failures++; $display("FAIL illegal_size_nowrite got=%h want=%h", rd, m_rd); end
      do_req(1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, 2'b01, 1'b0, 0, rd, er, lat, st, rr);
      checks++; if (er !== 1'b0) begin failures++; $display("FAIL amp_zero_err got=%b want=0", er); end
      model(1'b0, 32'h24, 32'h0, 4'h0, 2'b01, 1'b0, m_rd, m_er);
      do_req(1'b0, 32'h24, 32'h0, 4'h0, 2'b01, 1'b0, 0, rd, er, lat, st, rr);
      checks++; if (rd !== m_rd) begin failures++; $display("FAIL amp_zero_nowrite got=%h want=%h", rd, m_rd); end
   endtask

   task automatic test_reset_in_access;
      logic [31:0] rd, m_rd; logic er, m_er, st, rr; int lat, n;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5;
      req_amp = 4'hF; req_swhb = 2'b01; req_unsigned = 1'b0;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_access_valid got=%b want=0", rsp_valid); end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_access_ready got rdy=%b vld=%b want rdy=1 vld=0", req_ready, rsp_valid); end
      model(1'b0, 32'h20, 32'h0, 4'h0, 2'b01, 1'b0, m_rd, m_er);
      do_req(1'b0, 32'h20, 32'h0, 4'h0, 2'b01, 1'b0, 0, rd, er, lat, st, rr);
      checks++; if (rd !== m_rd || er !== 1'b0) begin failures++; $display("FAIL rst_access_nowrite got=%h want=%h", rd, m_rd); end
   endtask

   task automatic test_random;
      logic [31:0] rd, m_rd, a, w; logic er, m_er, st, rr, we, uns; logic [3:0] amp; logic [1:0] sz;
      int lat, hold, sel;
      for (int i = 0; i < 250; i++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0)      a = 32'(4*DEPTH) + $urandom_range(0, 100000);
         else if (sel <= 2) a = 32'(4*(DEPTH-10)) + $urandom_range(0, 39);
         else               a = $urandom_range(0, 255);
         we   = 1'($urandom);
         w    = $urandom;
         amp  = 4'($urandom);
         sz   = ($urandom_range(0, 15) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         uns  = 1'($urandom);
         hold = $urandom_range(0, 3);
         model(we, a, w, amp, sz, uns, m_rd, m_er);
         do_req(we, a, w, amp, sz, uns, hold, rd, er, lat, st, rr);
         checks++; if (rd !== m_rd || er !== m_er) begin failures++; $display("FAIL rand_rsp i=%0d we=%b a=%h sz=%b u=%b got err=%b rd=%h want err=%b rd=%h", i, we, a, sz, uns, er, rd, m_er, m_rd); end
         checks++; if (lat !== 2) begin failures++; $display("FAIL rand_latency i=%0d got=%0d want=2", i, lat); end
         checks++; if (st !== 1'b1 || rr !== 1'b1) begin failures++; $display("FAIL rand_handshake i=%0d stable=%b ready_after=%b want 1 1", i, st, rr); end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_directed();
      test_backpressure();
      test_errors();
      test_reset_in_access();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
